// File: rtl/ivl_uvm_ovl_fire_pkg.sv
// -----------------------------------------------------------------------------
// ivl_uvm_ovl_fire_pkg
// Shared definitions for the OVL fire collector.
//   - Bit positions inside each checker's 3-bit fire field.
//   - sat_inc(): saturating increment, usable for any counter width < 32.
//   - Event record layout: {time, xfail mask, fail mask}, with fail in the
//     least significant NUM_CHK bits.
// -----------------------------------------------------------------------------
package ivl_uvm_ovl_fire_pkg;

  // Bit positions within one checker's fire field.
  localparam int FIRE_2STATE = 0;
  localparam int FIRE_XCHECK = 1;
  localparam int FIRE_COVER  = 2;
  localparam int FIRE_BITS   = 3;

  // Event record field order, counted from the LSB in units of fields:
  // fail mask first, then xfail mask, then timestamp.
  localparam int EVT_FIELD_FAIL  = 0;
  localparam int EVT_FIELD_XFAIL = 1;
  localparam int EVT_FIELD_TIME  = 2;

  // Returns val+1, or holds at 2^width-1. Callers cast the result back to
  // their own counter width.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input int unsigned width);
    logic [31:0] max_val;
    max_val = (32'd1 << width) - 32'd1;
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/ivl_uvm_ovl_fire_fifo.sv
// -----------------------------------------------------------------------------
// ivl_uvm_ovl_fire_fifo
// Generic synchronous FIFO with a valid/ready read side.
//   clock, reset   : clock, synchronous active-high reset
//   i_push, i_data : write request and data (accepted when not full, or when
//                    full and a pop happens in the same cycle)
//   o_full         : all DEPTH entries occupied
//   o_valid,o_data : head entry; o_data reads 0 while empty
//   i_ready        : consumer accepts the head (pop when o_valid & i_ready)
// DEPTH must be a power of two, at least 2.
// -----------------------------------------------------------------------------
module ivl_uvm_ovl_fire_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_full,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra MSB so full and empty are distinguishable.
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_wr;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = !w_empty && i_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_wr    = i_push && (!w_full || w_pop);

  assign o_full  = w_full;
  assign o_valid = !w_empty;
  assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers define which
  // entries are live and the output is masked while empty.
  always_ff @(posedge clock) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/ivl_uvm_ovl_fire_collector.sv
// -----------------------------------------------------------------------------
// ivl_uvm_ovl_fire_collector
// Collects OVL checker fire outputs into timestamped events, per-checker
// saturating failure counters and sticky summary flags.
//   clock, reset         : clock, synchronous active-high reset
//   enable               : 0 ignores fire_in (timestamp keeps running)
//   fire_in[3k+2:3k]     : checker k {cover, xcheck fail, 2-state fail}
//   clear                : zeroes counters and sticky flags (not the FIFO)
//   evt_valid/evt_ready  : event FIFO head handshake
//   evt_time/fail/xfail  : head event fields (0 while empty)
//   fail_cnt             : checker k count at [k*CNT_W +: CNT_W]
//   drop_cnt, overflow   : events lost to a full FIFO
//   any_fail             : any qualified hit since reset/clear
// Build option: define IVL_UVM_OVL_FIRE_EDGE_EN to count only rising edges of
// (fail | xfail) per checker instead of every active cycle.
// -----------------------------------------------------------------------------
module ivl_uvm_ovl_fire_collector
  import ivl_uvm_ovl_fire_pkg::*;
#(
  parameter int NUM_CHK    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8,
  parameter int TS_W       = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [3*NUM_CHK-1:0]     fire_in,
  input  logic                     clear,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [TS_W-1:0]          evt_time,
  output logic [NUM_CHK-1:0]       evt_fail,
  output logic [NUM_CHK-1:0]       evt_xfail,
  output logic [NUM_CHK*CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic                     any_fail,
  output logic                     overflow
);

  localparam int EVT_W = TS_W + 2 * NUM_CHK;

  logic [TS_W-1:0]    r_ts;
  logic [CNT_W-1:0]   r_fail_cnt [NUM_CHK];
  logic [CNT_W-1:0]   r_drop_cnt;
  logic               r_any_fail;
  logic               r_overflow;

  logic [NUM_CHK-1:0] w_lvl;
  logic [NUM_CHK-1:0] w_fail_bit;
  logic [NUM_CHK-1:0] w_xfail_bit;
  logic [NUM_CHK-1:0] w_cover_bit;
  logic [NUM_CHK-1:0] w_hit;
  logic               w_hit_any;
  logic               w_fifo_full;
  logic               w_pop;
  logic               w_drop;
  logic [EVT_W-1:0]   w_evt_in;
  logic [EVT_W-1:0]   w_evt_out;
  logic               w_unused_cover;

  for (genvar k = 0; k < NUM_CHK; k++) begin : g_split
    assign w_fail_bit[k]  = fire_in[FIRE_BITS*k + FIRE_2STATE];
    assign w_xfail_bit[k] = fire_in[FIRE_BITS*k + FIRE_XCHECK];
    assign w_cover_bit[k] = fire_in[FIRE_BITS*k + FIRE_COVER];
    assign w_lvl[k]       = w_fail_bit[k] | w_xfail_bit[k];
  end

  // Cover bits carry no failure information.
  assign w_unused_cover = |w_cover_bit;

`ifdef IVL_UVM_OVL_FIRE_EDGE_EN
  logic [NUM_CHK-1:0] r_prev_lvl;

  // Previous level tracks the raw inputs regardless of enable, so a fire
  // already high when enable rises does not count as a new edge.
  always_ff @(posedge clock) begin
    if (reset) r_prev_lvl <= '0;
    else       r_prev_lvl <= w_lvl;
  end

  assign w_hit = {NUM_CHK{enable}} & w_lvl & ~r_prev_lvl;
`else
  assign w_hit = {NUM_CHK{enable}} & w_lvl;
`endif

  assign w_hit_any = |w_hit;
  assign w_pop     = evt_valid & evt_ready;
  assign w_drop    = w_hit_any & w_fifo_full & ~w_pop;

  // Masks only report checkers that produced a qualified hit this cycle.
  assign w_evt_in  = {r_ts, w_hit & w_xfail_bit, w_hit & w_fail_bit};

  ivl_uvm_ovl_fire_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_hit_any),
    .i_data  (w_evt_in),
    .o_full  (w_fifo_full),
    .o_valid (evt_valid),
    .i_ready (evt_ready),
    .o_data  (w_evt_out)
  );

  assign evt_fail  = w_evt_out[EVT_FIELD_FAIL*NUM_CHK  +: NUM_CHK];
  assign evt_xfail = w_evt_out[EVT_FIELD_XFAIL*NUM_CHK +: NUM_CHK];
  assign evt_time  = w_evt_out[EVT_FIELD_TIME*NUM_CHK  +: TS_W];

  // Free-running timestamp; wraps silently.
  always_ff @(posedge clock) begin
    if (reset) r_ts <= '0;
    else       r_ts <= r_ts + 1'b1;
  end

  // A hit coinciding with clear counts from zero.
  for (genvar k = 0; k < NUM_CHK; k++) begin : g_cnt
    always_ff @(posedge clock) begin
      if (reset)
        r_fail_cnt[k] <= '0;
      else if (w_hit[k])
        r_fail_cnt[k] <= CNT_W'(sat_inc(clear ? 32'd0 : 32'(r_fail_cnt[k]), CNT_W));
      else if (clear)
        r_fail_cnt[k] <= '0;
    end
    assign fail_cnt[k*CNT_W +: CNT_W] = r_fail_cnt[k];
  end

  always_ff @(posedge clock) begin
    if (reset)
      r_drop_cnt <= '0;
    else if (w_drop)
      r_drop_cnt <= CNT_W'(sat_inc(clear ? 32'd0 : 32'(r_drop_cnt), CNT_W));
    else if (clear)
      r_drop_cnt <= '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_any_fail <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_any_fail <= (r_any_fail & ~clear) | w_hit_any;
      r_overflow <= (r_overflow & ~clear) | w_drop;
    end
  end

  assign drop_cnt = r_drop_cnt;
  assign any_fail = r_any_fail;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_ivl_uvm_ovl_fire_collector.sv
// -----------------------------------------------------------------------------
// tb_ivl_uvm_ovl_fire_collector
// Self-checking bench: directed scenarios plus randomized traffic, all
// compared every cycle against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_ivl_uvm_ovl_fire_collector;

  localparam int NUM_CHK    = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int CNT_W      = 8;
  localparam int TS_W       = 16;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic                     clock = 1'b0;
  logic                     reset = 1'b1;
  logic                     enable = 1'b0;
  logic [3*NUM_CHK-1:0]     fire_in = '0;
  logic                     clear = 1'b0;
  logic                     evt_valid;
  logic                     evt_ready = 1'b0;
  logic [TS_W-1:0]          evt_time;
  logic [NUM_CHK-1:0]       evt_fail;
  logic [NUM_CHK-1:0]       evt_xfail;
  logic [NUM_CHK*CNT_W-1:0] fail_cnt;
  logic [CNT_W-1:0]         drop_cnt;
  logic                     any_fail;
  logic                     overflow;

  ivl_uvm_ovl_fire_collector #(
    .NUM_CHK(NUM_CHK), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W), .TS_W(TS_W)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .fire_in(fire_in),
    .clear(clear), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_time(evt_time), .evt_fail(evt_fail), .evt_xfail(evt_xfail),
    .fail_cnt(fail_cnt), .drop_cnt(drop_cnt), .any_fail(any_fail),
    .overflow(overflow)
  );

  always #5 clock = ~clock;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int                 t;
    logic [NUM_CHK-1:0] f;
    logic [NUM_CHK-1:0] x;
  } evt_t;

  evt_t               m_q[$];
  int                 m_ts;
  int                 m_cnt [NUM_CHK];
  int                 m_drop;
  bit                 m_any;
  bit                 m_ovf;
  bit [NUM_CHK-1:0]   m_prev;

  task automatic model_reset();
    m_q.delete();
    m_ts = 0; m_drop = 0; m_any = 0; m_ovf = 0; m_prev = '0;
    for (int k = 0; k < NUM_CHK; k++) m_cnt[k] = 0;
  endtask

  task automatic model_cycle(input logic [3*NUM_CHK-1:0] f, input bit en,
                             input bit rdy, input bit clr);
    bit [NUM_CHK-1:0] hit;
    evt_t e;
    for (int k = 0; k < NUM_CHK; k++) begin
      bit lvl;
      lvl = f[3*k] | f[3*k+1];
`ifdef IVL_UVM_OVL_FIRE_EDGE_EN
      hit[k] = en & lvl & ~m_prev[k];
`else
      hit[k] = en & lvl;
`endif
      m_prev[k] = lvl;
      e.f[k] = hit[k] & f[3*k];
      e.x[k] = hit[k] & f[3*k+1];
    end
    e.t = m_ts;
    if (rdy && m_q.size() > 0) void'(m_q.pop_front());
    if (clr) begin
      for (int k = 0; k < NUM_CHK; k++) m_cnt[k] = 0;
      m_drop = 0; m_any = 0; m_ovf = 0;
    end
    if (hit != 0) begin
      m_any = 1;
      for (int k = 0; k < NUM_CHK; k++)
        if (hit[k] && m_cnt[k] < CNT_MAX) m_cnt[k]++;
      if (m_q.size() < FIFO_DEPTH) m_q.push_back(e);
      else begin
        if (m_drop < CNT_MAX) m_drop++;
        m_ovf = 1;
      end
    end
    m_ts = (m_ts + 1) % (1 << TS_W);
  endtask

  task automatic check_all();
    check("evt_valid", evt_valid, m_q.size() > 0);
    if (m_q.size() > 0) begin
      check("evt_time",  evt_time,  m_q[0].t);
      check("evt_fail",  evt_fail,  m_q[0].f);
      check("evt_xfail", evt_xfail, m_q[0].x);
    end else begin
      check("evt_idle", {evt_time, evt_fail, evt_xfail}, 0);
    end
    for (int k = 0; k < NUM_CHK; k++)
      check($sformatf("fail_cnt%0d", k), fail_cnt[k*CNT_W +: CNT_W], m_cnt[k]);
    check("drop_cnt", drop_cnt, m_drop);
    check("any_fail", any_fail, m_any);
    check("overflow", overflow, m_ovf);
  endtask

  // Drive inputs, advance one clock, then compare at the falling edge.
  task automatic step(input logic [3*NUM_CHK-1:0] f, input bit en,
                      input bit rdy, input bit clr, input bit rst);
    fire_in = f; enable = en; evt_ready = rdy; clear = clr; reset = rst;
    if (rst) model_reset();
    else     model_cycle(f, en, rdy, clr);
    @(posedge clock);
    @(negedge clock);
    check_all();
  endtask

  function automatic logic [3*NUM_CHK-1:0] bit_of(input int chk, input int b);
    logic [3*NUM_CHK-1:0] v;
    v = '0;
    v[3*chk + b] = 1'b1;
    return v;
  endfunction

  initial begin
    @(negedge clock);
    step('0, 1, 1, 0, 1);
    step('0, 1, 1, 0, 1);
    check("rst_valid", evt_valid, 0);
    check("rst_any", any_fail, 0);
    check("rst_cnt", fail_cnt, 0);

    // Idle until timestamp 5, then a single-cycle fail on checker 1.
    for (int i = 0; i < 5; i++) step('0, 1, 1, 0, 0);
    step(bit_of(1, 0), 1, 1, 0, 0);
    check("pulse_time", evt_time, 5);
    check("pulse_fail", evt_fail, 4'b0010);
    check("pulse_cnt1", fail_cnt[1*CNT_W +: CNT_W], 1);
    check("pulse_any", any_fail, 1);
    for (int i = 0; i < 10; i++) step('0, 1, 1, 0, 0);

    // Two checkers in one cycle share a single event.
    step(bit_of(0, 0) | bit_of(3, 1), 1, 1, 0, 0);
    check("share_fail", evt_fail, 4'b0001);
    check("share_xfail", evt_xfail, 4'b1000);
    step('0, 1, 1, 0, 0);
    check("share_one", evt_valid, 0);

    // Overflow: checker 2 held 12 cycles with the consumer stalled.
    step('0, 1, 0, 0, 1);
    for (int i = 0; i < 12; i++) step(bit_of(2, 0), 1, 0, 0, 0);
`ifndef IVL_UVM_OVL_FIRE_EDGE_EN
    check("ovf_drop", drop_cnt, 4);
    check("ovf_flag", overflow, 1);
    check("ovf_cnt2", fail_cnt[2*CNT_W +: CNT_W], 12);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      check("drain_time", evt_time, i);
      step('0, 1, 1, 0, 0);
    end
`else
    for (int i = 0; i < FIFO_DEPTH; i++) step('0, 1, 1, 0, 0);
`endif
    check("drained", evt_valid, 0);

    // Saturation then clear, with events left in the FIFO.
    for (int i = 0; i < 300; i++) step(bit_of(0, 0), 1, 1, 0, 0);
`ifndef IVL_UVM_OVL_FIRE_EDGE_EN
    check("sat_cnt0", fail_cnt[CNT_W-1:0], CNT_MAX);
`endif
    step(bit_of(3, 1), 1, 0, 0, 0);
    step(bit_of(1, 0), 1, 0, 1, 0);
    check("clr_hit_cnt1", fail_cnt[1*CNT_W +: CNT_W], 1);
    check("clr_cnt0", fail_cnt[CNT_W-1:0], 0);
    step('0, 1, 0, 1, 0);
    check("clr_any", any_fail, 0);
    for (int i = 0; i < 4; i++) step('0, 1, 1, 0, 0);

    // Edge pattern: 5 high, 1 low, 2 high, then reset mid-burst.
    step('0, 1, 1, 0, 1);
    for (int i = 0; i < 5; i++) step(bit_of(0, 0), 1, 1, 0, 0);
    step('0, 1, 1, 0, 0);
    for (int i = 0; i < 2; i++) step(bit_of(0, 0), 1, 1, 0, 0);
`ifdef IVL_UVM_OVL_FIRE_EDGE_EN
    check("edge_cnt0", fail_cnt[CNT_W-1:0], 2);
`else
    check("level_cnt0", fail_cnt[CNT_W-1:0], 7);
`endif
    step(bit_of(0, 0), 1, 0, 0, 0);
    step(bit_of(0, 0), 1, 0, 0, 1);
    check("midrst_valid", evt_valid, 0);
    check("midrst_cnt", fail_cnt, 0);
    check("midrst_any", any_fail, 0);

    // Enable low: nothing recorded.
    for (int i = 0; i < 6; i++) step(bit_of(i % NUM_CHK, 1), 0, 1, 0, 0);
    check("dis_any", any_fail, 0);

    // Randomized traffic in phases of varying density and backpressure.
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 400; i++) begin
        logic [3*NUM_CHK-1:0] f;
        for (int b = 0; b < 3*NUM_CHK; b++)
          f[b] = ($urandom_range(0, 7) < ph + 1);
        step(f,
             $urandom_range(0, 9) != 0,
             $urandom_range(0, 3) < (ph == 2 ? 1 : 3),
             $urandom_range(0, 39) == 0,
             $urandom_range(0, 199) == 0);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
